gate_pair_edge_counter: RTL and testbench

//  Downstream monitor for the dual AND-OR gate pair: consumes p1y/p2y, which change with no fixed relation to clk.
//  Per channel: 2-flop synchronise, debounce, count rising edges.

---
 rtl/gate_pair_edge_counter_pkg.sv | 14 +
 rtl/gate_pair_edge_counter_if.sv | 37 +++
 rtl/gate_pair_edge_counter_sync_debounce.sv | 62 ++++++
 rtl/gate_pair_edge_counter.sv | 138 +++++++++++++
 tb/tb_gate_pair_edge_counter.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gate_pair_edge_counter_pkg.sv
// gate_pair_pkg: shared types and default sizes for the gate-pair edge monitor.
//   snap_state_t      - snapshot handshake state (IDLE / HOLD)
//   STABLE_CYCLES_DEF - default debounce length in clk cycles
//   CNT_W_DEF         - default edge counter / snapshot width
//   NUM_CH            - number of monitored gate outputs (p1y, p2y)
package gate_pair_pkg;

  typedef enum logic {IDLE, HOLD} snap_state_t;

  localparam int STABLE_CYCLES_DEF = 4;
  localparam int CNT_W_DEF         = 8;
  localparam int NUM_CH            = 2;

endpackage

// File: rtl/gate_pair_edge_counter_if.sv
// gate_pair_edge_counter_if: snapshot request/valid/ready bus between the edge
// monitor and the register/readout logic.
//   snap_req   - readout asks for a snapshot (sampled every cycle)
//   snap_ready - readout accepts the held snapshot
//   snap_valid - snapshot fields below hold valid data
//   p1_cnt     - channel-1 rising-edge count at snapshot time
//   p2_cnt     - channel-2 rising-edge count at snapshot time
//   p1_sat     - channel-1 counter had saturated
//   p2_sat     - channel-2 counter had saturated
//   snap_drop  - 1-cycle pulse, a snap_req arrived while a snapshot was held
// Modports: master = readout side, slave = monitor side.
interface gate_pair_edge_counter_if
  import gate_pair_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             snap_req;
  logic             snap_ready;
  logic             snap_valid;
  logic [CNT_W-1:0] p1_cnt;
  logic [CNT_W-1:0] p2_cnt;
  logic             p1_sat;
  logic             p2_sat;
  logic             snap_drop;

  modport master (
    output snap_req, snap_ready,
    input  snap_valid, p1_cnt, p2_cnt, p1_sat, p2_sat, snap_drop
  );

  modport slave (
    input  snap_req, snap_ready,
    output snap_valid, p1_cnt, p2_cnt, p1_sat, p2_sat, snap_drop
  );

endinterface

// File: rtl/gate_pair_edge_counter_sync_debounce.sv
// sync_debounce: one monitored channel.
//   2-flop synchroniser, then a debounce filter that only accepts a new level
//   after it has differed from the filtered level for STABLE_CYCLES
//   consecutive cycles, then a rising-edge pulse on the filtered level.
// Ports:
//   clk    - rising-edge clock
//   resetn - asynchronous active-low reset
//   d      - raw input, asynchronous to clk
//   filt   - debounced level
//   rise   - 1-cycle pulse in the cycle after filt goes 0->1
module sync_debounce #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic filt,
  output logic rise
);

  localparam int            DW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [DW-1:0] DBC_LAST = DW'(STABLE_CYCLES - 1);

  logic          s1, s2;
  logic          filt_q, filt_prev_q;
  logic [DW-1:0] dbc_q;

  // s1 is the metastability-catching stage: nothing but s2 may read it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  // Any cycle where s2 agrees with the filtered level restarts the run, so
  // only an uninterrupted disagreement of STABLE_CYCLES cycles gets through.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      dbc_q       <= '0;
    end else begin
      filt_prev_q <= filt_q;
      if (s2 == filt_q) begin
        dbc_q <= '0;
      end else if (dbc_q == DBC_LAST) begin
        filt_q <= s2;
        dbc_q  <= '0;
      end else begin
        dbc_q <= dbc_q + 1'b1;
      end
    end
  end

  assign filt = filt_q;
  assign rise = filt_q & ~filt_prev_q;

endmodule

// File: rtl/gate_pair_edge_counter.sv
// gate_pair_edge_counter: downstream monitor for the dual AND-OR gate pair.
//   Each gate output is synchronised and debounced, its filtered rising edges
//   are counted in a saturating counter with a sticky saturation flag, and
//   both counts are handed to the readout logic through a snapshot handshake.
// Parameters:
//   STABLE_CYCLES - debounce length in cycles (>=1)
//   CNT_W         - counter / snapshot width (2..16)
//   CLEAR_ON_SNAP - 1: live counters and sticky flags restart at each snapshot
// Ports:
//   clk, resetn        - clock, asynchronous active-low reset
//   p1y, p2y           - gate outputs, asynchronous to clk
//   p1y_filt, p2y_filt - debounced gate outputs
//   snap               - snapshot bus (slave side)
module gate_pair_edge_counter
  import gate_pair_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter bit CLEAR_ON_SNAP = 1'b1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    p1y,
  input  logic                    p2y,
  output logic                    p1y_filt,
  output logic                    p2y_filt,
  gate_pair_edge_counter_if.slave snap
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Lane 0 is channel 1 (p1y), lane 1 is channel 2 (p2y).
  logic [NUM_CH-1:0]            din, filt, rise;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_inc, out_cnt_q;
  logic [NUM_CH-1:0]            sat_q, out_sat_q;
  logic                         drop_q, drop_d;
  logic                         capture, clr_live;
  snap_state_t                  state_q, state_d;

  assign din = {p2y, p1y};

  sync_debounce #(.STABLE_CYCLES(STABLE_CYCLES)) u_ch [NUM_CH-1:0] (
    .clk    (clk),
    .resetn (resetn),
    .d      (din),
    .filt   (filt),
    .rise   (rise)
  );

  assign p1y_filt = filt[0];
  assign p2y_filt = filt[1];

  // ---------------------------------------------------------------------------
  // Live counters and sticky saturation flags
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_inc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_inc[i] = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + 1'b1;
    end
  end

  // On a clearing snapshot the counter restarts at the same-cycle edge, if
  // any, so that edge lands in the new window instead of being lost.
  // The flag sets whenever the post-edge value is max, which covers both
  // reaching max and a further edge while already at max.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      sat_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (clr_live) begin
          cnt_q[i] <= rise[i] ? CNT_ONE : '0;
          sat_q[i] <= 1'b0;
        end else if (rise[i]) begin
          cnt_q[i] <= cnt_inc[i];
          if (cnt_inc[i] == CNT_MAX) sat_q[i] <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Snapshot FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // A request while holding is refused even if the readout accepts in the
  // same cycle; the readout must ask again once back in IDLE.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (snap.snap_req) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (snap.snap_req)   drop_d  = 1'b1;
        if (snap.snap_ready) state_d = IDLE;
      end
    endcase
  end

  assign clr_live = capture & CLEAR_ON_SNAP;

  // Capture takes the pre-edge count; outputs stay put outside a capture,
  // including after the handshake completes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_cnt_q <= '0;
      out_sat_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      drop_q <= drop_d;
      if (capture) begin
        out_cnt_q <= cnt_q;
        out_sat_q <= sat_q;
      end
    end
  end

  assign snap.snap_valid = (state_q == HOLD);
  assign snap.p1_cnt     = out_cnt_q[0];
  assign snap.p2_cnt     = out_cnt_q[1];
  assign snap.p1_sat     = out_sat_q[0];
  assign snap.p2_sat     = out_sat_q[1];
  assign snap.snap_drop  = drop_q;

endmodule

// File: tb/tb_gate_pair_edge_counter.sv
// Bench for gate_pair_edge_counter. Three instances share all stimulus:
//   d0: STABLE_CYCLES=4 CNT_W=8 CLEAR_ON_SNAP=1
//   d1: STABLE_CYCLES=4 CNT_W=4 CLEAR_ON_SNAP=1
//   d2: STABLE_CYCLES=4 CNT_W=8 CLEAR_ON_SNAP=0
// The reference model counts accepted pulses per channel per instance.
module tb_gate_pair_edge_counter;

  localparam int ND = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic p1y = 1'b0, p2y = 1'b0;
  logic snap_req = 1'b0, snap_ready = 1'b0;

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int max_v [ND] = '{255, 15, 255};
  bit clr_v [ND] = '{1'b1, 1'b1, 1'b0};
  int live  [ND][2];
  bit sat   [ND][2];
  int ec1 [ND], ec2 [ND];
  bit es1 [ND], es2 [ND];

  // observed DUT outputs
  logic [ND-1:0] f1, f2, vld, drp, s1, s2, seen1;
  logic [31:0]   c1 [ND], c2 [ND];

  bit tmp [$];
  bit q1 [$], q2 [$];

  gate_pair_edge_counter_if #(.CNT_W(8)) sif0 ();
  gate_pair_edge_counter_if #(.CNT_W(4)) sif1 ();
  gate_pair_edge_counter_if #(.CNT_W(8)) sif2 ();

  assign sif0.snap_req = snap_req;  assign sif0.snap_ready = snap_ready;
  assign sif1.snap_req = snap_req;  assign sif1.snap_ready = snap_ready;
  assign sif2.snap_req = snap_req;  assign sif2.snap_ready = snap_ready;

  gate_pair_edge_counter #(.STABLE_CYCLES(4), .CNT_W(8), .CLEAR_ON_SNAP(1'b1)) dut0 (
    .clk(clk), .resetn(resetn), .p1y(p1y), .p2y(p2y),
    .p1y_filt(f1[0]), .p2y_filt(f2[0]), .snap(sif0));
  gate_pair_edge_counter #(.STABLE_CYCLES(4), .CNT_W(4), .CLEAR_ON_SNAP(1'b1)) dut1 (
    .clk(clk), .resetn(resetn), .p1y(p1y), .p2y(p2y),
    .p1y_filt(f1[1]), .p2y_filt(f2[1]), .snap(sif1));
  gate_pair_edge_counter #(.STABLE_CYCLES(4), .CNT_W(8), .CLEAR_ON_SNAP(1'b0)) dut2 (
    .clk(clk), .resetn(resetn), .p1y(p1y), .p2y(p2y),
    .p1y_filt(f1[2]), .p2y_filt(f2[2]), .snap(sif2));

  assign vld = {sif2.snap_valid, sif1.snap_valid, sif0.snap_valid};
  assign drp = {sif2.snap_drop,  sif1.snap_drop,  sif0.snap_drop};
  assign s1  = {sif2.p1_sat,     sif1.p1_sat,     sif0.p1_sat};
  assign s2  = {sif2.p2_sat,     sif1.p2_sat,     sif0.p2_sat};
  assign c1[0] = 32'(sif0.p1_cnt);  assign c2[0] = 32'(sif0.p2_cnt);
  assign c1[1] = 32'(sif1.p1_cnt);  assign c2[1] = 32'(sif1.p2_cnt);
  assign c1[2] = 32'(sif2.p1_cnt);  assign c2[2] = 32'(sif2.p2_cnt);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // one clock, then sample away from the edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      seen1 = seen1 | f1;
    end
  endtask

  // model: n accepted pulses on channel ch for every instance
  task automatic add(input int ch, input int n);
    for (int d = 0; d < ND; d++)
      for (int k = 0; k < n; k++) begin
        if (live[d][ch] < max_v[d]) live[d][ch]++;
        if (live[d][ch] == max_v[d]) sat[d][ch] = 1'b1;
      end
  endtask

  // model: snapshot reports the live state, then optionally clears it
  task automatic cmp_snap(input string tag);
    for (int d = 0; d < ND; d++) begin
      ec1[d] = live[d][0];  ec2[d] = live[d][1];
      es1[d] = sat[d][0];   es2[d] = sat[d][1];
      chk($sformatf("%s_d%0d_p1cnt", tag, d), c1[d], ec1[d]);
      chk($sformatf("%s_d%0d_p2cnt", tag, d), c2[d], ec2[d]);
      chk($sformatf("%s_d%0d_p1sat", tag, d), 32'(s1[d]), 32'(es1[d]));
      chk($sformatf("%s_d%0d_p2sat", tag, d), 32'(s2[d]), 32'(es2[d]));
      if (clr_v[d]) begin
        live[d][0] = 0;  live[d][1] = 0;
        sat[d][0]  = 0;  sat[d][1]  = 0;
      end
    end
  endtask

  task automatic take_snap(input string tag);
    snap_req = 1'b1;
    tick(1);
    snap_req = 1'b0;
    chk({tag, "_valid"}, 32'(vld), 32'(3'b111));
  endtask

  task automatic release_snap(input string tag);
    snap_ready = 1'b1;
    tick(1);
    snap_ready = 1'b0;
    chk({tag, "_rel_valid"}, 32'(vld), 32'd0);
  endtask

  // n clean pulses, with optional short glitches in the low phase and short
  // dips in the high phase; only the clean pulses survive the filter
  task automatic gen(input int n);
    tmp.delete();
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(9, 5)) tmp.push_back(1'b0);
      if ($urandom_range(1, 0) == 1) begin
        repeat ($urandom_range(3, 1)) tmp.push_back(1'b1);
        repeat (5) tmp.push_back(1'b0);
      end
      repeat ($urandom_range(9, 5)) tmp.push_back(1'b1);
      if ($urandom_range(1, 0) == 1) begin
        repeat ($urandom_range(3, 1)) tmp.push_back(1'b0);
        repeat ($urandom_range(9, 5)) tmp.push_back(1'b1);
      end
    end
  endtask

  task automatic round(input string tag, input int n1, input int n2);
    int len;
    gen(n1);  q1 = tmp;
    gen(n2);  q2 = tmp;
    len = (q1.size() > q2.size()) ? q1.size() : q2.size();
    for (int i = 0; i < len; i++) begin
      p1y = (i < q1.size()) ? q1[i] : 1'b0;
      p2y = (i < q2.size()) ? q2[i] : 1'b0;
      tick(1);
    end
    p1y = 1'b0;  p2y = 1'b0;
    tick(12);
    add(0, n1);
    add(1, n2);
    take_snap(tag);
    cmp_snap(tag);
  endtask

  int first1 [ND], first2 [ND];
  bit got_rise;

  initial begin
    for (int d = 0; d < ND; d++) begin
      live[d][0] = 0; live[d][1] = 0; sat[d][0] = 0; sat[d][1] = 0;
      first1[d] = 0;  first2[d] = 0;
    end
    seen1 = '0;

    // ---- 1: reset state, then filter latency on a held level
    tick(3);
    p1y = 1'b1;  p2y = 1'b1;
    tick(2);
    chk("rst_p1filt", 32'(f1), 32'd0);
    chk("rst_p2filt", 32'(f2), 32'd0);
    chk("rst_valid",  32'(vld), 32'd0);
    chk("rst_drop",   32'(drp), 32'd0);
    chk("rst_sat",    32'({s2, s1}), 32'd0);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst_d%0d_cnt", d), c1[d] | c2[d], 32'd0);
    end
    resetn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      for (int d = 0; d < ND; d++) begin
        if (f1[d] && first1[d] == 0) first1[d] = k;
        if (f2[d] && first2[d] == 0) first2[d] = k;
      end
    end
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("t1_d%0d_p1_latency", d), first1[d], 32'd6);
      chk($sformatf("t1_d%0d_p2_latency", d), first2[d], 32'd6);
    end
    p1y = 1'b0;  p2y = 1'b0;
    tick(12);
    add(0, 1);  add(1, 1);
    take_snap("t1");
    cmp_snap("t1");
    release_snap("t1");

    // ---- 2: 3-cycle pulse rejected, 5-cycle pulse accepted
    seen1 = '0;
    p1y = 1'b1;  tick(3);
    p1y = 1'b0;  tick(10);
    chk("t2_short_filt", 32'(seen1), 32'd0);
    seen1 = '0;
    p1y = 1'b1;  tick(5);
    p1y = 1'b0;  tick(12);
    chk("t2_long_filt", 32'(seen1), 32'(3'b111));
    add(0, 1);
    take_snap("t2");
    cmp_snap("t2");
    release_snap("t2");

    // ---- 3: 5 and 3 clean pulses, then an empty window
    round("t3a", 5, 3);
    release_snap("t3a");
    round("t3b", 0, 0);
    release_snap("t3b");

    // ---- 4: saturate the narrow instance, then check the flag restarts
    round("t4a", $urandom_range(6, 0), 20);
    release_snap("t4a");
    round("t4b", $urandom_range(12, 0), $urandom_range(12, 0));

    // ---- 5: request while holding is dropped, outputs stay
    snap_req = 1'b1;
    tick(1);
    snap_req = 1'b0;
    chk("t5_drop", 32'(drp), 32'(3'b111));
    chk("t5_hold_valid", 32'(vld), 32'(3'b111));
    tick(1);
    chk("t5_drop_end", 32'(drp), 32'd0);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("t5_d%0d_p1cnt_hold", d), c1[d], ec1[d]);
      chk($sformatf("t5_d%0d_p2cnt_hold", d), c2[d], ec2[d]);
    end
    snap_req = 1'b1;  snap_ready = 1'b1;
    tick(1);
    snap_req = 1'b0;  snap_ready = 1'b0;
    chk("t5_drop_on_ready", 32'(drp), 32'(3'b111));
    chk("t5_rel_valid", 32'(vld), 32'd0);
    tick(1);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("t5_d%0d_p1cnt_keep", d), c1[d], ec1[d]);
      chk($sformatf("t5_d%0d_p1sat_keep", d), 32'(s1[d]), 32'(es1[d]));
    end
    round("t5b", $urandom_range(20, 0), $urandom_range(20, 0));
    release_snap("t5b");
    round("t5c", $urandom_range(20, 0), $urandom_range(20, 0));
    release_snap("t5c");

    // ---- 6: snapshot in the same cycle as a filtered rise
    got_rise = 1'b0;
    p1y = 1'b1;
    for (int k = 0; k < 20 && !got_rise; k++) begin
      tick(1);
      if (f1[0]) got_rise = 1'b1;
    end
    chk("t6_wait_rise", 32'(got_rise), 32'd1);
    take_snap("t6a");
    cmp_snap("t6a");
    add(0, 1);
    p1y = 1'b0;
    release_snap("t6a");
    tick(12);
    take_snap("t6b");
    cmp_snap("t6b");
    release_snap("t6b");

    // ---- 7: asynchronous reset while holding
    p1y = 1'b1;
    tick(10);
    add(0, 1);
    take_snap("t7");
    cmp_snap("t7");
    #2;
    resetn = 1'b0;
    #1;
    chk("t7_valid", 32'(vld), 32'd0);
    chk("t7_filt",  32'(f1), 32'd0);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("t7_d%0d_p1cnt", d), c1[d], 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
